axi4_sram_slave: RTL and testbench

//  Single-beat AXI4 slave SRAM that sits directly downstream of the AHB-to-AXI4 bridge and consumes its AW/W/AR channels.

---
 rtl/axi4_sram_slave.sv | 254 +++++++++++++++++++++++++
 tb/tb_axi4_sram_slave.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_sram_slave.sv
// Single-beat AXI4 SRAM slave with independent write and read paths.
// Optional response wait states are enabled by defining AXI4_SRAM_WAIT_EN.
//
// state  | meaning
// W_IDLE | collecting AW and W; commit when both are held
// W_RESP | write response pending (B valid once any wait expires)
// R_IDLE | ready for an AR handshake
// R_DATA | read response pending (R valid once any wait expires)
module axi4_sram_slave #(
  parameter int          TAG         = 1,
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst_l,
  input  logic           axi_awvalid,
  output logic           axi_awready,
  input  logic [TAG-1:0] axi_awid,
  input  logic [31:0]    axi_awaddr,
  input  logic [2:0]     axi_awsize,
  input  logic [2:0]     axi_awprot,
  input  logic [1:0]     axi_awburst,
  input  logic [7:0]     axi_awlen,
  input  logic           axi_wvalid,
  output logic           axi_wready,
  input  logic [63:0]    axi_wdata,
  input  logic [7:0]     axi_wstrb,
  input  logic           axi_wlast,
  output logic           axi_bvalid,
  input  logic           axi_bready,
  output logic [1:0]     axi_bresp,
  output logic [TAG-1:0] axi_bid,
  input  logic           axi_arvalid,
  output logic           axi_arready,
  input  logic [TAG-1:0] axi_arid,
  input  logic [31:0]    axi_araddr,
  input  logic [2:0]     axi_arsize,
  input  logic [2:0]     axi_arprot,
  input  logic [1:0]     axi_arburst,
  input  logic [7:0]     axi_arlen,
  output logic           axi_rvalid,
  input  logic           axi_rready,
  output logic [TAG-1:0] axi_rid,
  output logic [63:0]    axi_rdata,
  output logic [1:0]     axi_rresp
);

  localparam int          IDXW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN        = 33'(DEPTH_WORDS) * 33'd8;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  function automatic logic [1:0] decode_resp(input logic [31:0] addr, input logic [7:0] len);
    logic [32:0] a;
    logic [32:0] lo;
    a  = {1'b0, addr};
    lo = {1'b0, BASE_ADDR};
    if (a < lo || a >= lo + SPAN) return RESP_DECERR;
    if (len != 8'd0) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  function automatic logic [IDXW-1:0] word_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return IDXW'(off >> 3);
  endfunction

  logic [63:0] mem_q [DEPTH_WORDS];

  wstate_t         wstate_q, wstate_d;
  logic            aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [TAG-1:0]  awid_q, awid_d, bid_q, bid_d;
  logic [IDXW-1:0] awidx_q, awidx_d;
  logic [1:0]      awresp_q, awresp_d, bresp_q, bresp_d;
  logic [63:0]     wdata_q, wdata_d;
  logic [7:0]      wstrb_q, wstrb_d;
  logic            bvalid_q, bvalid_d, awready_q, awready_d, wready_q, wready_d;

  rstate_t         rstate_q, rstate_d;
  logic [TAG-1:0]  rid_q, rid_d;
  logic [1:0]      rresp_q, rresp_d;
  logic [63:0]     rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d, arready_q, arready_d;

  logic commit, ar_hs, wwait_d, rwait_d;

  assign commit = (wstate_q == W_IDLE) & aw_held_q & w_held_q;
  assign ar_hs  = (rstate_q == R_IDLE) & axi_arvalid & arready_q;

`ifdef AXI4_SRAM_WAIT_EN
  logic [3:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;

  always_comb begin
    wcnt_d = wcnt_q;
    rcnt_d = rcnt_q;
    if (commit) wcnt_d = 4'(WAIT_CYCLES);
    else if (wcnt_q != 4'd0) wcnt_d = wcnt_q - 4'd1;
    if (ar_hs) rcnt_d = 4'(WAIT_CYCLES);
    else if (rcnt_q != 4'd0) rcnt_d = rcnt_q - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wcnt_q <= 4'd0;
      rcnt_q <= 4'd0;
    end else begin
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
    end
  end

  assign wwait_d = (wcnt_d != 4'd0);
  assign rwait_d = (rcnt_d != 4'd0);
`else
  logic unused_wait;
  assign unused_wait = ^4'(WAIT_CYCLES);
  assign wwait_d     = 1'b0;
  assign rwait_d     = 1'b0;
`endif

  always_comb begin
    wstate_d  = wstate_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awid_d    = awid_q;
    awidx_d   = awidx_q;
    awresp_d  = awresp_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    bid_d     = bid_q;
    case (wstate_q)
      W_IDLE: begin
        if (axi_awvalid && awready_q) begin
          aw_held_d = 1'b1;
          awid_d    = axi_awid;
          awidx_d   = word_idx(axi_awaddr);
          awresp_d  = decode_resp(axi_awaddr, axi_awlen);
        end
        if (axi_wvalid && wready_q) begin
          w_held_d = 1'b1;
          wdata_d  = axi_wdata;
          wstrb_d  = axi_wstrb;
        end
        if (commit) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bresp_d   = awresp_q;
          bid_d     = awid_q;
          wstate_d  = W_RESP;
        end
      end
      W_RESP: if (bvalid_q && axi_bready) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
    bvalid_d  = (wstate_d == W_RESP) & ~wwait_d;
    awready_d = (wstate_d == W_IDLE) & ~aw_held_d;
    wready_d  = (wstate_d == W_IDLE) & ~w_held_d;
  end

  always_comb begin
    rstate_d = rstate_q;
    rid_d    = rid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    case (rstate_q)
      R_IDLE: if (ar_hs) begin
        rid_d    = axi_arid;
        rresp_d  = decode_resp(axi_araddr, axi_arlen);
        rdata_d  = (rresp_d == RESP_OKAY) ? mem_q[word_idx(axi_araddr)] : 64'd0;
        rstate_d = R_DATA;
      end
      R_DATA: if (rvalid_q && axi_rready) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
    rvalid_d  = (rstate_d == R_DATA) & ~rwait_d;
    arready_d = (rstate_d == R_IDLE);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wstate_q  <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awid_q    <= '0;
      awidx_q   <= '0;
      awresp_q  <= RESP_OKAY;
      wdata_q   <= 64'd0;
      wstrb_q   <= 8'd0;
      bresp_q   <= RESP_OKAY;
      bid_q     <= '0;
      bvalid_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      rstate_q  <= R_IDLE;
      rid_q     <= '0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= 64'd0;
      rvalid_q  <= 1'b0;
      arready_q <= 1'b0;
    end else begin
      wstate_q  <= wstate_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awid_q    <= awid_d;
      awidx_q   <= awidx_d;
      awresp_q  <= awresp_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      bid_q     <= bid_d;
      bvalid_q  <= bvalid_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      rstate_q  <= rstate_d;
      rid_q     <= rid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      arready_q <= arready_d;
    end
  end

  // Memory array is deliberately left out of reset; a read in the commit cycle sees the old word.
  always_ff @(posedge clk) begin
    if (commit && awresp_q == RESP_OKAY) begin
      for (int b = 0; b < 8; b++) begin
        if (wstrb_q[b]) mem_q[awidx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{axi_awsize, axi_awprot, axi_awburst, axi_wlast,
                       axi_arsize, axi_arprot, axi_arburst};

  assign axi_awready = awready_q;
  assign axi_wready  = wready_q;
  assign axi_bvalid  = bvalid_q;
  assign axi_bresp   = bresp_q;
  assign axi_bid     = bid_q;
  assign axi_arready = arready_q;
  assign axi_rvalid  = rvalid_q;
  assign axi_rid     = rid_q;
  assign axi_rdata   = rdata_q;
  assign axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed plus randomized bench for axi4_sram_slave against a word-array reference model.
module tb_axi4_sram_slave;
  localparam int          TAG   = 4;
  localparam int          DEPTH = 64;
  localparam int          WAITC = 3;
  localparam logic [31:0] BASE  = 32'h0000_1000;
`ifdef AXI4_SRAM_WAIT_EN
  localparam int LAT = WAITC;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  logic           axi_awvalid = 0, axi_awready;
  logic [TAG-1:0] axi_awid = '0;
  logic [31:0]    axi_awaddr = '0;
  logic [2:0]     axi_awsize = 3'd3, axi_awprot = '0;
  logic [1:0]     axi_awburst = 2'd1;
  logic [7:0]     axi_awlen = '0;
  logic           axi_wvalid = 0, axi_wready;
  logic [63:0]    axi_wdata = '0;
  logic [7:0]     axi_wstrb = '0;
  logic           axi_wlast = 1'b1;
  logic           axi_bvalid, axi_bready = 0;
  logic [1:0]     axi_bresp;
  logic [TAG-1:0] axi_bid;
  logic           axi_arvalid = 0, axi_arready;
  logic [TAG-1:0] axi_arid = '0;
  logic [31:0]    axi_araddr = '0;
  logic [2:0]     axi_arsize = 3'd3, axi_arprot = '0;
  logic [1:0]     axi_arburst = 2'd1;
  logic [7:0]     axi_arlen = '0;
  logic           axi_rvalid, axi_rready = 0;
  logic [TAG-1:0] axi_rid;
  logic [63:0]    axi_rdata;
  logic [1:0]     axi_rresp;

  axi4_sram_slave #(.TAG(TAG), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst_l(rst_l),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awid(axi_awid),
    .axi_awaddr(axi_awaddr), .axi_awsize(axi_awsize), .axi_awprot(axi_awprot),
    .axi_awburst(axi_awburst), .axi_awlen(axi_awlen),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
    .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp), .axi_bid(axi_bid),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arid(axi_arid),
    .axi_araddr(axi_araddr), .axi_arsize(axi_arsize), .axi_arprot(axi_arprot),
    .axi_arburst(axi_arburst), .axi_arlen(axi_arlen),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rid(axi_rid),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] mdl [DEPTH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_resp(input logic [31:0] addr, input logic [7:0] len);
    longint a, lo, hi;
    a  = longint'({32'd0, addr});
    lo = longint'({32'd0, BASE});
    hi = lo + DEPTH * 8;
    if (a < lo || a >= hi) return 2'b11;
    if (len != 8'd0) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int widx(input logic [31:0] addr);
    return int'((addr - BASE) >> 3);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb);
    for (int b = 0; b < 8; b++)
      if (strb[b]) mdl[widx(addr)][8*b +: 8] = data[8*b +: 8];
  endtask

  task automatic write_txn(input string tag, input logic [31:0] addr, input logic [TAG-1:0] id,
                           input logic [63:0] data, input logic [7:0] strb, input logic [7:0] len,
                           input int w_lead, input int bhold);
    logic aw_done, w_done;
    logic [1:0] er;
    int n, cnt;
    er = exp_resp(addr, len);
    axi_awaddr = addr; axi_awid = id; axi_awlen = len;
    axi_wdata = data; axi_wstrb = strb;
    aw_done = 0; w_done = 0;
    if (w_lead > 0) begin
      axi_wvalid = 1; n = 0;
      while (!axi_wready && n < 40) begin step(); n++; end
      step();
      axi_wvalid = 0; w_done = 1;
      repeat (w_lead - 1) step();
    end
    axi_awvalid = 1;
    if (!w_done) axi_wvalid = 1;
    n = 0;
    while (!(aw_done && w_done) && n < 40) begin
      if (axi_awvalid && axi_awready) aw_done = 1;
      if (axi_wvalid && axi_wready) w_done = 1;
      step(); n++;
      if (aw_done) axi_awvalid = 0;
      if (w_done) axi_wvalid = 0;
    end
    axi_awvalid = 0; axi_wvalid = 0;
    chk({tag, "_aw_w_hs"}, {62'd0, aw_done, w_done}, 64'd3);
    n = 0;
    while (!axi_bvalid && n < 40) begin step(); n++; end
    chk({tag, "_b_latency"}, 64'(n), 64'(1 + LAT));
    chk({tag, "_bresp"}, 64'(axi_bresp), 64'(er));
    chk({tag, "_bid"}, 64'(axi_bid), 64'(id));
    if (bhold > 0) begin
      cnt = 0;
      repeat (bhold) begin
        step();
        if (axi_bvalid === 1'b1 && axi_bresp === er && axi_bid === id) cnt++;
      end
      chk({tag, "_b_hold"}, 64'(cnt), 64'(bhold));
    end
    axi_bready = 1;
    step();
    axi_bready = 0;
    chk({tag, "_w_ready_after_b"}, {61'd0, axi_awready, axi_wready, axi_bvalid}, 64'b110);
    if (er == 2'b00) model_write(addr, data, strb);
  endtask

  task automatic read_txn(input string tag, input logic [31:0] addr, input logic [TAG-1:0] id,
                          input logic [7:0] len, input int rhold, output logic [63:0] rd);
    logic [1:0] er;
    logic [63:0] ed;
    int n, cnt;
    er = exp_resp(addr, len);
    ed = (er == 2'b00) ? mdl[widx(addr)] : 64'd0;
    axi_araddr = addr; axi_arid = id; axi_arlen = len;
    axi_arvalid = 1; n = 0;
    while (!axi_arready && n < 40) begin step(); n++; end
    step();
    axi_arvalid = 0;
    n = 0;
    while (!axi_rvalid && n < 40) begin step(); n++; end
    chk({tag, "_r_latency"}, 64'(n), 64'(LAT));
    rd = axi_rdata;
    chk({tag, "_rdata"}, axi_rdata, ed);
    chk({tag, "_rid"}, 64'(axi_rid), 64'(id));
    chk({tag, "_rresp"}, 64'(axi_rresp), 64'(er));
    if (rhold > 0) begin
      cnt = 0;
      repeat (rhold) begin
        step();
        if (axi_rvalid === 1'b1 && axi_rdata === ed && axi_rid === id) cnt++;
      end
      chk({tag, "_r_hold"}, 64'(cnt), 64'(rhold));
    end
    axi_rready = 1;
    step();
    axi_rready = 0;
    chk({tag, "_ar_ready_after_r"}, {62'd0, axi_arready, axi_rvalid}, 64'b10);
  endtask

  function automatic logic [31:0] rand_addr();
    int k;
    k = int'($urandom_range(0, 15));
    if (k == 0) return BASE + DEPTH * 8 + 8 * $urandom_range(0, 3) + $urandom_range(0, 7);
    if (k == 1) return BASE - 8 * $urandom_range(1, 4);
    return BASE + 8 * $urandom_range(0, DEPTH - 1) + $urandom_range(0, 7);
  endfunction

  initial begin
    logic [63:0] rd, old;
    logic got_r, got_b;
    int n;

    // Reset release
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_readies", {61'd0, axi_awready, axi_wready, axi_arready}, 64'd0);
    chk("rst_valids", {62'd0, axi_bvalid, axi_rvalid}, 64'd0);
    rst_l = 1;
    #1;
    chk("rel_readies_pre_edge", {61'd0, axi_awready, axi_wready, axi_arready}, 64'd0);
    step();
    chk("rel_readies", {61'd0, axi_awready, axi_wready, axi_arready}, 64'b111);

    for (int i = 0; i < DEPTH; i++)
      write_txn("init", BASE + 32'(i) * 8, 4'(i), {$urandom, $urandom}, 8'hFF, 8'd0, 0, 0);

    write_txn("t2", BASE + 32'h40, 4'd1, 64'h1122334455667788, 8'hFF, 8'd0, 0, 0);
    read_txn("t2", BASE + 32'h40, 4'd1, 8'd0, 0, rd);
    chk("t2_lit", rd, 64'h1122334455667788);

    write_txn("t3", BASE + 32'h40, 4'd2, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, 8'd0, 2, 5);
    read_txn("t3", BASE + 32'h40, 4'd3, 8'd0, 2, rd);
    chk("t3_lit", rd, 64'h11223344_BBBBBBBB);

    read_txn("t4_top", BASE + DEPTH * 8, 4'd5, 8'd0, 0, rd);
    read_txn("t4_below", BASE - 8, 4'd6, 8'd0, 0, rd);
    read_txn("t4_arlen", BASE + 32'h48, 4'd7, 8'd1, 0, rd);
    write_txn("t4_awlen", BASE + 32'h48, 4'd8, 64'hDEAD_BEEF_0000_0001, 8'hFF, 8'd3, 0, 0);
    write_txn("t4_decerr", BASE + DEPTH * 8 + 8, 4'd9, 64'hDEAD_BEEF_0000_0002, 8'hFF, 8'd3, 1, 0);
    write_txn("t4_strb0", BASE + 32'h48, 4'd10, 64'hDEAD_BEEF_0000_0003, 8'h00, 8'd0, 0, 0);
    read_txn("t4_unchanged", BASE + 32'h48, 4'd11, 8'd0, 0, rd);

    // Write commits in the same cycle as the AR handshake to the same word
    old = mdl[widx(BASE + 32'h40)];
    axi_awaddr = BASE + 32'h40; axi_awid = 4'd12; axi_awlen = 8'd0;
    axi_wdata = '1; axi_wstrb = 8'hFF;
    axi_awvalid = 1; axi_wvalid = 1; axi_bready = 1; axi_rready = 1;
    chk("t5_w_ready", {62'd0, axi_awready, axi_wready}, 64'b11);
    step();
    axi_awvalid = 0; axi_wvalid = 0;
    axi_araddr = BASE + 32'h40; axi_arid = 4'd13; axi_arlen = 8'd0; axi_arvalid = 1;
    chk("t5_arready", 64'(axi_arready), 64'd1);
    step();
    axi_arvalid = 0;
    got_r = 0; got_b = 0; n = 0; rd = '0;
    while (!(got_r && got_b) && n < 40) begin
      if (axi_rvalid && !got_r) begin got_r = 1; rd = axi_rdata; end
      if (axi_bvalid) got_b = 1;
      step(); n++;
    end
    axi_bready = 0; axi_rready = 0;
    chk("t5_both_resp", {62'd0, got_r, got_b}, 64'b11);
    chk("t5_old_data", rd, old);
    model_write(BASE + 32'h40, '1, 8'hFF);
    read_txn("t5_second", BASE + 32'h40, 4'd14, 8'd0, 0, rd);
    chk("t5_lit", rd, 64'hFFFF_FFFF_FFFF_FFFF);

    // Reset while bvalid is high
    axi_awaddr = BASE + 32'h80; axi_awid = 4'd3; axi_awlen = 8'd0;
    axi_wdata = 64'h0123_4567_89AB_CDEF; axi_wstrb = 8'hFF;
    axi_awvalid = 1; axi_wvalid = 1;
    step();
    axi_awvalid = 0; axi_wvalid = 0;
    n = 0;
    while (!axi_bvalid && n < 40) begin step(); n++; end
    chk("t6_bvalid_seen", 64'(axi_bvalid), 64'd1);
    model_write(BASE + 32'h80, 64'h0123_4567_89AB_CDEF, 8'hFF);
    #2 rst_l = 0;
    #1;
    chk("t6_bvalid_drop", 64'(axi_bvalid), 64'd0);
    chk("t6_readies_low", {61'd0, axi_awready, axi_wready, axi_arready}, 64'd0);
    @(negedge clk);
    rst_l = 1;
    step();
    chk("t6_readies_back", {61'd0, axi_awready, axi_wready, axi_arready}, 64'b111);
    chk("t6_bvalid_after", 64'(axi_bvalid), 64'd0);
    read_txn("t6_committed", BASE + 32'h80, 4'd4, 8'd0, 0, rd);

    // Held W discarded by reset
    axi_wdata = 64'h5555_5555_5555_5555; axi_wstrb = 8'hFF; axi_wvalid = 1;
    step();
    axi_wvalid = 0;
    #2 rst_l = 0;
    @(negedge clk);
    rst_l = 1;
    step();
    read_txn("t6_w_discard", BASE + 32'h88, 4'd2, 8'd0, 0, rd);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      logic [7:0] len;
      a = rand_addr();
      len = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      if ($urandom_range(0, 1) == 0)
        write_txn("rnd_wr", a, 4'($urandom), {$urandom, $urandom}, 8'($urandom), len,
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      else
        read_txn("rnd_rd", a, 4'($urandom), len, int'($urandom_range(0, 2)), rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
